dds_sweep_controller: RTL and testbench

- Upstream stage of the CORDIC-table DDS. Drives its SET and step_in ports so the DDS output sweeps from a start frequency to a stop frequency in programmable increments, holding each step for a programmable dwell.
- Supports single-shot or repeating sweeps. Can optionally align each step change to a DDS phase-zero event, using the DDS zero_address output.

---
 rtl/dds_sweep_controller_pkg.sv | 25 ++
 rtl/dds_step_adder.sv | 21 ++
 rtl/dds_sweep_controller.sv | 139 +++++++++++++
 tb/tb_dds_sweep_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_sweep_controller_pkg.sv
// Shared definitions for the DDS frequency-sweep controller and the DDS it drives.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dds_sweep_controller_pkg;

    // Default widths, kept in step with the CORDIC-table DDS
    localparam int DDS_ADDRESS_WIDTH = 8;
    localparam int SWEEP_DWELL_WIDTH = 16;

    // Sweep FSM state encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DWELL = 3'd2;
    localparam logic [2:0] S_ALIGN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        LOAD  = S_LOAD,
        DWELL = S_DWELL,
        ALIGN = S_ALIGN,
        DONE  = S_DONE
    } sweep_state_t;

endpackage

// File: rtl/dds_step_adder.sv
// Next-step adder: nxt = cur + step_inc, flags end of sweep on zero increment, overshoot or overflow.
// Latency: combinational, no registers.
// Backpressure: none.
module dds_step_adder #(
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic [ADDRESS_WIDTH-1:0] cur,
    input  logic [ADDRESS_WIDTH-1:0] step_inc,
    input  logic [ADDRESS_WIDTH-1:0] stop_step,
    output logic [ADDRESS_WIDTH-1:0] nxt,
    output logic                     end_of_sweep
);

    // One extra bit keeps the carry so a wrapped sum can never look like a small valid step
    logic [ADDRESS_WIDTH:0] sum;

    assign sum          = {1'b0, cur} + {1'b0, step_inc};
    assign nxt          = sum[ADDRESS_WIDTH-1:0];
    assign end_of_sweep = (step_inc == '0) || (sum > {1'b0, stop_step});

endmodule

// File: rtl/dds_sweep_controller.sv
// Steps the DDS phase increment from start_step to stop_step, holding each value for a dwell period.
// Latency: first SET one cycle after start; later SETs every max(dwell,1)+1 cycles (plus zero-phase wait if enabled).
// Backpressure: none; start is ignored while busy, abort preempts everything.
module dds_sweep_controller
    import dds_sweep_controller_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DDS_ADDRESS_WIDTH,
    parameter int DWELL_WIDTH   = SWEEP_DWELL_WIDTH,
    parameter int INITIAL_STEP  = 1,
    parameter int WAIT_ZERO     = 0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     repeat_en,
    input  logic [ADDRESS_WIDTH-1:0] start_step,
    input  logic [ADDRESS_WIDTH-1:0] stop_step,
    input  logic [ADDRESS_WIDTH-1:0] step_inc,
    input  logic [DWELL_WIDTH-1:0]   dwell_cycles,
    input  logic                     zero_address,
    output logic                     SET,
    output logic [ADDRESS_WIDTH-1:0] step_out,
    output logic                     busy,
    output logic                     done
);

    localparam logic [ADDRESS_WIDTH-1:0] INIT_STEP = ADDRESS_WIDTH'(INITIAL_STEP);

    sweep_state_t             state;
    logic [ADDRESS_WIDTH-1:0] cur;
    logic [ADDRESS_WIDTH-1:0] cfg_start;
    logic [ADDRESS_WIDTH-1:0] cfg_stop;
    logic [ADDRESS_WIDTH-1:0] cfg_inc;
    logic [DWELL_WIDTH-1:0]   cfg_dwell;
    logic                     cfg_repeat;
    logic [DWELL_WIDTH-1:0]   dwell_cnt;

    logic [ADDRESS_WIDTH-1:0] nxt;
    logic                     end_of_sweep;
    logic [ADDRESS_WIDTH-1:0] next_cur;

    dds_step_adder #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_step_adder (
        .cur          (cur),
        .step_inc     (cfg_inc),
        .stop_step    (cfg_stop),
        .nxt          (nxt),
        .end_of_sweep (end_of_sweep)
    );

    // Value loaded next: restart value when the sweep wraps, otherwise the incremented step
    assign next_cur = end_of_sweep ? cfg_start : nxt;

    // Sweep FSM with registered SET/step_out/busy/done; outputs are set on entry to each state
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            SET        <= 1'b0;
            step_out   <= INIT_STEP;
            busy       <= 1'b0;
            done       <= 1'b0;
            dwell_cnt  <= '0;
            cur        <= INIT_STEP;
            cfg_start  <= '0;
            cfg_stop   <= '0;
            cfg_inc    <= '0;
            cfg_dwell  <= DWELL_WIDTH'(1);
            cfg_repeat <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            SET   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            SET  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_start  <= start_step;
                        cfg_stop   <= stop_step;
                        cfg_inc    <= step_inc;
                        cfg_dwell  <= (dwell_cycles == '0) ? DWELL_WIDTH'(1) : dwell_cycles;
                        cfg_repeat <= repeat_en;
                        cur        <= start_step;
                        step_out   <= start_step;
                        SET        <= 1'b1;
                        busy       <= 1'b1;
                        dwell_cnt  <= '0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    dwell_cnt <= DWELL_WIDTH'(1);
                    state     <= DWELL;
                end
                DWELL: begin
                    if (dwell_cnt == cfg_dwell) begin
                        if (end_of_sweep && !cfg_repeat) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cur <= next_cur;
                            if (WAIT_ZERO != 0) begin
                                state <= ALIGN;
                            end else begin
                                step_out  <= next_cur;
                                SET       <= 1'b1;
                                dwell_cnt <= '0;
                                state     <= LOAD;
                            end
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
                    end
                end
                ALIGN: begin
                    if (zero_address) begin
                        step_out  <= cur;
                        SET       <= 1'b1;
                        dwell_cnt <= '0;
                        state     <= LOAD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sweep_controller.sv
module tb_dds_sweep_controller;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       repeat_en = 1'b0;
    logic [7:0] start_step = 8'd0;
    logic [7:0] stop_step = 8'd0;
    logic [7:0] step_inc = 8'd0;
    logic [15:0] dwell_cycles = 16'd0;
    logic       zero_a = 1'b0;
    logic       SET;
    logic [7:0] step_out;
    logic       busy;
    logic       done;

    // Second instance with zero-phase alignment, driven by a small DDS phase model
    logic       start_w = 1'b0;
    logic       abort_w = 1'b0;
    logic       zero_w;
    logic       SET_w;
    logic [7:0] step_w;
    logic       busy_w;
    logic       done_w;
    logic [7:0] phase;
    logic [7:0] dds_step;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    dds_sweep_controller #(
        .ADDRESS_WIDTH(8), .DWELL_WIDTH(16), .INITIAL_STEP(1), .WAIT_ZERO(0)
    ) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .abort(abort), .repeat_en(repeat_en),
        .start_step(start_step), .stop_step(stop_step), .step_inc(step_inc),
        .dwell_cycles(dwell_cycles), .zero_address(zero_a),
        .SET(SET), .step_out(step_out), .busy(busy), .done(done)
    );

    dds_sweep_controller #(
        .ADDRESS_WIDTH(8), .DWELL_WIDTH(16), .INITIAL_STEP(1), .WAIT_ZERO(1)
    ) dut_wz (
        .CLK(CLK), .RESET(RESET), .start(start_w), .abort(abort_w), .repeat_en(repeat_en),
        .start_step(start_step), .stop_step(stop_step), .step_inc(step_inc),
        .dwell_cycles(dwell_cycles), .zero_address(zero_w),
        .SET(SET_w), .step_out(step_w), .busy(busy_w), .done(done_w)
    );

    // DDS phase accumulator: SET clears phase and loads the new increment
    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase    <= 8'd0;
            dds_step <= 8'd0;
        end else if (SET_w) begin
            phase    <= 8'd0;
            dds_step <= step_w;
        end else begin
            phase <= phase + dds_step;
        end
    end
    assign zero_w = (phase == 8'd0);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg(input logic [7:0] s, input logic [7:0] e, input logic [7:0] inc,
                       input logic [15:0] d, input logic rep);
        start_step   = s;
        stop_step    = e;
        step_inc     = inc;
        dwell_cycles = d;
        repeat_en    = rep;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        total++; if (SET !== 1'b0) begin bad++; $display("FAIL reset_set got=%b exp=0", SET); end
        total++; if (step_out !== 8'd1) begin bad++; $display("FAIL reset_step got=%0d exp=1", step_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (step_w !== 8'd1) begin bad++; $display("FAIL reset_step_wz got=%0d exp=1", step_w); end
        RESET = 1'b0;
        tick();
    endtask

    // 10..40 by 10, dwell 3; also a start pulse during the DONE cycle that must be ignored
    task automatic test_basic();
        logic       exp_set;
        logic [7:0] exp_step;
        cfg(8'd10, 8'd40, 8'd10, 16'd3, 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            exp_set  = (c == 1) || (c == 5) || (c == 9) || (c == 13);
            exp_step = (c <= 16) ? 8'(10 * ((c - 1) / 4 + 1)) : 8'd40;
            total++; if (SET !== exp_set) begin bad++; $display("FAIL basic_set c=%0d got=%b exp=%b", c, SET, exp_set); end
            total++; if (step_out !== exp_step) begin bad++; $display("FAIL basic_step c=%0d got=%0d exp=%0d", c, step_out, exp_step); end
            total++; if (done !== (c == 17)) begin bad++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, done, (c == 17)); end
            total++; if (busy !== (c <= 16)) begin bad++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy, (c <= 16)); end
            if (c == 17) start = 1'b1;
            if (c == 18) start = 1'b0;
        end
    endtask

    // 250 + 4 = 254 is legal, 258 overflows 8 bits and must end the sweep
    task automatic test_overflow();
        logic       exp_set;
        logic [7:0] exp_step;
        cfg(8'd250, 8'd255, 8'd4, 16'd2, 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            exp_set  = (c == 1) || (c == 4);
            exp_step = (c < 4) ? 8'd250 : 8'd254;
            total++; if (SET !== exp_set) begin bad++; $display("FAIL ovf_set c=%0d got=%b exp=%b", c, SET, exp_set); end
            total++; if (step_out !== exp_step) begin bad++; $display("FAIL ovf_step c=%0d got=%0d exp=%0d", c, step_out, exp_step); end
            total++; if (done !== (c == 7)) begin bad++; $display("FAIL ovf_done c=%0d got=%b exp=%b", c, done, (c == 7)); end
            total++; if (busy !== (c <= 6)) begin bad++; $display("FAIL ovf_busy c=%0d got=%b exp=%b", c, busy, (c <= 6)); end
        end
    endtask

    // 5,6,7,5,6 with SET every 2 cycles, then abort during a would-be LOAD, then start+abort together
    task automatic test_repeat_abort();
        logic [7:0] seq [3];
        logic       exp_set;
        logic [7:0] exp_step;
        seq[0] = 8'd5; seq[1] = 8'd6; seq[2] = 8'd7;
        cfg(8'd5, 8'd7, 8'd1, 16'd1, 1'b1);
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            exp_set  = (c % 2) == 1;
            exp_step = seq[((c - 1) / 2) % 3];
            total++; if (SET !== exp_set) begin bad++; $display("FAIL rep_set c=%0d got=%b exp=%b", c, SET, exp_set); end
            total++; if (step_out !== exp_step) begin bad++; $display("FAIL rep_step c=%0d got=%0d exp=%0d", c, step_out, exp_step); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL rep_done c=%0d got=%b exp=0", c, done); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL rep_busy c=%0d got=%b exp=1", c, busy); end
        end
        abort = 1'b1;
        for (int c = 11; c <= 14; c++) begin
            tick();
            if (c == 11) abort = 1'b0;
            total++; if (SET !== 1'b0) begin bad++; $display("FAIL abort_set c=%0d got=%b exp=0", c, SET); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy c=%0d got=%b exp=0", c, busy); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done c=%0d got=%b exp=0", c, done); end
            total++; if (step_out !== 8'd6) begin bad++; $display("FAIL abort_step c=%0d got=%0d exp=6", c, step_out); end
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 2; c++) begin
            total++; if (SET !== 1'b0) begin bad++; $display("FAIL startabort_set c=%0d got=%b exp=0", c, SET); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL startabort_busy c=%0d got=%b exp=0", c, busy); end
            tick();
        end
    endtask

    // Zero dwell / zero increment, and start_step above stop_step: one step then done
    task automatic test_degenerate();
        logic [7:0] ss;
        for (int k = 0; k < 2; k++) begin
            ss = (k == 0) ? 8'd20 : 8'd50;
            if (k == 0) cfg(ss, 8'd100, 8'd0, 16'd0, 1'b0);
            else        cfg(ss, 8'd10, 8'd5, 16'd1, 1'b0);
            start = 1'b1;
            for (int c = 1; c <= 5; c++) begin
                tick();
                if (c == 1) start = 1'b0;
                total++; if (SET !== (c == 1)) begin bad++; $display("FAIL degen%0d_set c=%0d got=%b exp=%b", k, c, SET, (c == 1)); end
                total++; if (step_out !== ss) begin bad++; $display("FAIL degen%0d_step c=%0d got=%0d exp=%0d", k, c, step_out, ss); end
                total++; if (done !== (c == 3)) begin bad++; $display("FAIL degen%0d_done c=%0d got=%b exp=%b", k, c, done, (c == 3)); end
                total++; if (busy !== (c <= 2)) begin bad++; $display("FAIL degen%0d_busy c=%0d got=%b exp=%b", k, c, busy, (c <= 2)); end
            end
        end
    endtask

    // start with a different config mid-sweep must be ignored; RESET mid-dwell restores reset values
    task automatic test_robust();
        logic       exp_set;
        logic [7:0] exp_step;
        cfg(8'd10, 8'd40, 8'd10, 16'd3, 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            exp_set  = (c == 1) || (c == 5) || (c == 9);
            exp_step = 8'(10 * ((c - 1) / 4 + 1));
            total++; if (SET !== exp_set) begin bad++; $display("FAIL robust_set c=%0d got=%b exp=%b", c, SET, exp_set); end
            total++; if (step_out !== exp_step) begin bad++; $display("FAIL robust_step c=%0d got=%0d exp=%0d", c, step_out, exp_step); end
            if (c == 2) begin
                cfg(8'd99, 8'd200, 8'd50, 16'd7, 1'b1);
                start = 1'b1;
            end
            if (c == 3) start = 1'b0;
        end
        RESET = 1'b1;
        tick();
        total++; if (SET !== 1'b0) begin bad++; $display("FAIL midreset_set got=%b exp=0", SET); end
        total++; if (step_out !== 8'd1) begin bad++; $display("FAIL midreset_step got=%0d exp=1", step_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b exp=0", done); end
        RESET = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL postreset_busy got=%b exp=0", busy); end
    endtask

    // Every SET after the first must follow a cycle with zero_address high
    task automatic test_wait_zero();
        int   nset = 0;
        logic fin = 1'b0;
        logic prev_zero = 1'b0;
        cfg(8'd16, 8'd48, 8'd16, 16'd3, 1'b0);
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        for (int i = 0; i < 1500 && !fin; i++) begin
            if (SET_w) begin
                nset++;
                total++; if (step_w !== 8'(16 * nset)) begin bad++; $display("FAIL wz_step n=%0d got=%0d exp=%0d", nset, step_w, 16 * nset); end
                if (nset > 1) begin
                    total++; if (prev_zero !== 1'b1) begin bad++; $display("FAIL wz_align n=%0d prev_zero=%b exp=1", nset, prev_zero); end
                end
            end
            if (done_w) fin = 1'b1;
            prev_zero = zero_w;
            if (!fin) tick();
        end
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL wz_timeout done_seen=%b exp=1", fin); end
        total++; if (nset != 3) begin bad++; $display("FAIL wz_count got=%0d exp=3", nset); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_repeat_abort();
        test_degenerate();
        test_robust();
        test_wait_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
